// File: rtl/mac_operand_feeder.sv
//------------------------------------------------------------------------------
// mac_operand_feeder
//
// Upstream stage of the 4-bit MAC core. Host operand pairs are buffered in a
// small FIFO. Whenever TERMS pairs are waiting, a run is launched: a one-cycle
// go pulse, then TERMS consecutive cycles streaming one pair per cycle on a/b.
// After that the block waits for the core's done. A watchdog gives up after
// TIMEOUT cycles and raises a sticky error flag.
//
// Parameters:
//   DEPTH   - FIFO depth in pairs (power of two, >= 2, >= TERMS)
//   TERMS   - pairs per MAC run (1..DEPTH)
//   TIMEOUT - cycles allowed in WAIT_DONE before giving up (>= 1)
//
// Ports:
//   clk          in   clock, all logic on the rising edge
//   rst          in   synchronous active-high reset
//   in_valid     in   host offers {in_a, in_b}
//   in_a, in_b   in   host operands (4 bits each)
//   in_ready     out  FIFO not full (decoded from fifo_count)
//   go           out  one-cycle run-start pulse
//   a, b         out  operands to the core (0 outside FEED)
//   feed_valid   out  a/b carry a live pair this cycle
//   done         in   run complete from the core (used only in WAIT_DONE)
//   busy         out  FSM is not IDLE
//   fifo_count   out  pairs currently buffered
//   run_count    out  completed runs, wraps 255 -> 0
//   timeout_err  out  sticky watchdog flag, cleared only by rst
//------------------------------------------------------------------------------
module mac_operand_feeder #(
  parameter int DEPTH   = 16,
  parameter int TERMS   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  output logic                     in_ready,
  output logic                     go,
  output logic [3:0]               a,
  output logic [3:0]               b,
  output logic                     feed_valid,
  input  logic                     done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               run_count,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(TERMS + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
  localparam logic [CW-1:0] C_TERMS     = CW'(TERMS);
  localparam logic [BW-1:0] C_LAST_BEAT = BW'(TERMS - 1);
  localparam logic [WW-1:0] C_WD_LAST   = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_FEED,
    S_WAIT_DONE
  } state_t;

  state_t          r_state;
  state_t          w_nextState;

  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;
  logic [BW-1:0]   r_beat;
  logic [WW-1:0]   r_wdog;

  logic            w_push;
  logic            w_pop;
  logic [AW-1:0]   w_rdNext;
  logic [7:0]      w_headPair;
  logic            w_runDone;
  logic            w_runTimeout;

  // in_ready looks only at the current count, so a pop in the same cycle as
  // a full FIFO does not open the door for a push.
  assign in_ready   = (r_count != C_DEPTH);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = (r_state == S_FEED);
  assign fifo_count = r_count;

  // a/b are registered, so the pair loaded at an edge must be the head as it
  // will be after that edge's pop: one slot further on while still feeding.
  assign w_rdNext   = w_pop ? (r_rdPtr + AW'(1)) : r_rdPtr;
  assign w_headPair = r_mem[w_rdNext];

  // Next-state decode for the run sequencer; done only matters while waiting,
  // and a done in the final watchdog cycle still counts as a completed run.
  always_comb begin
    w_nextState  = r_state;
    w_runDone    = 1'b0;
    w_runTimeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count >= C_TERMS) begin
          w_nextState = S_START;
        end
      end
      S_START: begin
        w_nextState = S_FEED;
      end
      S_FEED: begin
        if (r_beat == C_LAST_BEAT) begin
          w_nextState = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (done) begin
          w_runDone   = 1'b1;
          w_nextState = S_IDLE;
        end else if (r_wdog == C_WD_LAST) begin
          w_runTimeout = 1'b1;
          w_nextState  = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // FIFO storage needs no reset: flushing is done by clearing the pointers
  // and the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {in_a, in_b};
    end
  end

  // State, FIFO bookkeeping, beat/watchdog counters and all registered
  // outputs. Outputs are computed from the next state so they line up with
  // the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_beat      <= '0;
      r_wdog      <= '0;
      go          <= 1'b0;
      a           <= '0;
      b           <= '0;
      feed_valid  <= 1'b0;
      busy        <= 1'b0;
      run_count   <= '0;
      timeout_err <= 1'b0;
    end else begin
      r_state <= w_nextState;

      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      r_rdPtr <= w_rdNext;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      r_beat <= (r_state == S_FEED)      ? (r_beat + BW'(1)) : '0;
      r_wdog <= (r_state == S_WAIT_DONE) ? (r_wdog + WW'(1)) : '0;

      go         <= (w_nextState == S_START);
      feed_valid <= (w_nextState == S_FEED);
      a          <= (w_nextState == S_FEED) ? w_headPair[7:4] : 4'd0;
      b          <= (w_nextState == S_FEED) ? w_headPair[3:0] : 4'd0;
      busy       <= (w_nextState != S_IDLE);

      if (w_runDone) begin
        run_count <= run_count + 8'd1;
      end
      if (w_runTimeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
//------------------------------------------------------------------------------
// tb_mac_operand_feeder
//
// Drives directed scenarios and randomized traffic into mac_operand_feeder.
// A reference model describes each run as a timeline counted from the go
// cycle (go at 0, feed at 1..TERMS, waiting afterwards) together with a
// queue of buffered pairs; every cycle all outputs are compared against it.
// Directed scenarios add literal expectations that pin the model itself.
//------------------------------------------------------------------------------
module tb_mac_operand_feeder;

  localparam int DEPTH   = 16;
  localparam int TERMS   = 4;
  localparam int TIMEOUT = 64;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          inValid;
  logic [3:0]    inA;
  logic [3:0]    inB;
  logic          done;
  logic          inReady;
  logic          go;
  logic [3:0]    a;
  logic [3:0]    b;
  logic          feedValid;
  logic          busy;
  logic [CW-1:0] fifoCount;
  logic [7:0]    runCount;
  logic          timeoutErr;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state: queue of buffered pairs, run timeline position
  // (-1 when no run is in progress), completed runs and the sticky error.
  logic [7:0] mQ[$];
  int         mRunT      = -1;
  int         mRunCount  = 0;
  bit         mErr       = 1'b0;
  bit         modelReady = 1'b0;

  always #5 clk = ~clk;

  mac_operand_feeder #(
    .DEPTH  (DEPTH),
    .TERMS  (TERMS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (inValid),
    .in_a       (inA),
    .in_b       (inB),
    .in_ready   (inReady),
    .go         (go),
    .a          (a),
    .b          (b),
    .feed_valid (feedValid),
    .done       (done),
    .busy       (busy),
    .fifo_count (fifoCount),
    .run_count  (runCount),
    .timeout_err(timeoutErr)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Holds the given inputs across one rising edge, returning 1 ns after it.
  task automatic applyStimulus(input int v, input int ia, input int ib, input int d, input int r);
    inValid = (v != 0);
    inA     = 4'(ia);
    inB     = 4'(ib);
    done    = (d != 0);
    rst     = (r != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
  endtask

  // Answers runs with random done until the model is idle with too few
  // pairs left to launch another run.
  task automatic drainRuns();
    int guard;
    guard = 0;
    while (!(mRunT < 0 && mQ.size() < TERMS) && guard < 1000) begin
      applyStimulus(0, 0, 0, (($urandom % 3) == 0) ? 1 : 0, 0);
      guard++;
    end
    if (guard >= 1000) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drainBound: model still busy after %0d cycles", guard);
    end
  endtask

  // Reference model, advanced at every rising edge from the inputs that were
  // stable before it.
  always @(posedge clk) begin : refModel
    int sizeBefore;
    int waited;
    bit doPush;
    bit doPop;
    if (rst) begin
      mQ.delete();
      mRunT      = -1;
      mRunCount  = 0;
      mErr       = 1'b0;
      modelReady = 1'b1;
    end else if (modelReady) begin
      sizeBefore = mQ.size();
      doPush     = inValid && (sizeBefore != DEPTH);
      doPop      = (mRunT >= 1 && mRunT <= TERMS);
      if (doPop) begin
        void'(mQ.pop_front());
      end
      if (doPush) begin
        mQ.push_back({inA, inB});
      end
      if (mRunT < 0) begin
        if (sizeBefore >= TERMS) begin
          mRunT = 0;
        end
      end else if (mRunT <= TERMS) begin
        mRunT++;
      end else begin
        waited = mRunT - (TERMS + 1);
        if (done) begin
          mRunT     = -1;
          mRunCount = (mRunCount + 1) % 256;
        end else if (waited + 1 == TIMEOUT) begin
          mRunT = -1;
          mErr  = 1'b1;
        end else begin
          mRunT++;
        end
      end
    end
  end

  // Every cycle, compare all outputs against the model mid-cycle.
  always @(negedge clk) begin : compare
    bit         expFeed;
    logic [7:0] head;
    if (modelReady) begin
      expFeed = (mRunT >= 1 && mRunT <= TERMS);
      head    = (mQ.size() > 0) ? mQ[0] : 8'h00;
      checkOutput("go", int'(go), int'(mRunT == 0));
      checkOutput("feed_valid", int'(feedValid), int'(expFeed));
      checkOutput("a", int'(a), expFeed ? int'(head[7:4]) : 0);
      checkOutput("b", int'(b), expFeed ? int'(head[3:0]) : 0);
      checkOutput("busy", int'(busy), int'(mRunT >= 0));
      checkOutput("fifo_count", int'(fifoCount), mQ.size());
      checkOutput("in_ready", int'(inReady), int'(mQ.size() != DEPTH));
      checkOutput("run_count", int'(runCount), mRunCount);
      checkOutput("timeout_err", int'(timeoutErr), int'(mErr));
    end
  end

  initial begin
    rst     = 1'b1;
    inValid = 1'b0;
    inA     = 4'd0;
    inB     = 4'd0;
    done    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Random activity, then reset must bring everything back.
    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom % 2, $urandom % 16, $urandom % 16, (($urandom % 4) == 0) ? 1 : 0, 0);
    end
    doReset();
    checkOutput("rst.go", int'(go), 0);
    checkOutput("rst.feed_valid", int'(feedValid), 0);
    checkOutput("rst.busy", int'(busy), 0);
    checkOutput("rst.fifo_count", int'(fifoCount), 0);
    checkOutput("rst.run_count", int'(runCount), 0);
    checkOutput("rst.timeout_err", int'(timeoutErr), 0);
    checkOutput("rst.in_ready", int'(inReady), 1);

    // Single run: (1,2) (3,4) (5,6) (7,8), then one cycle of done.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 2 * i + 1, 2 * i + 2, 0, 0);
    end
    checkOutput("run1.count4", int'(fifoCount), 4);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("run1.go", int'(go), 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("run1.feed", int'(feedValid), 1);
      checkOutput("run1.a", int'(a), 2 * i + 1);
      checkOutput("run1.b", int'(b), 2 * i + 2);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("run1.waitFeed", int'(feedValid), 0);
    checkOutput("run1.waitCount", int'(fifoCount), 0);
    checkOutput("run1.waitBusy", int'(busy), 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("run1.runCount", int'(runCount), 1);
    checkOutput("run1.idle", int'(busy), 0);

    // Full FIFO: 22 offers with the core held off; 20 get in.
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1, i % 16, 15 - (i % 16), 0, 0);
    end
    checkOutput("full.count", int'(fifoCount), 16);
    checkOutput("full.in_ready", int'(inReady), 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("full.runCount", int'(runCount), 2);
    drainRuns();

    // Simultaneous push and pop from a count of 5.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, i + 3, 12 - i, 0, 0);
    end
    checkOutput("pp.go", int'(go), 1);
    checkOutput("pp.countGo", int'(fifoCount), 5);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("pp.feed", int'(feedValid), 1);
      checkOutput("pp.count", int'(fifoCount), 5);
      applyStimulus(1, 9 - i, i + 1, 0, 0);
    end
    checkOutput("pp.countWait", int'(fifoCount), 5);
    drainRuns();

    // Watchdog: no done for a whole run.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, i + 9, i + 1, 0, 0);
    end
    repeat (6) applyStimulus(0, 0, 0, 0, 0);
    repeat (TIMEOUT - 1) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("tmo.errBefore", int'(timeoutErr), 0);
    checkOutput("tmo.busyBefore", int'(busy), 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("tmo.err", int'(timeoutErr), 1);
    checkOutput("tmo.idle", int'(busy), 0);
    checkOutput("tmo.runCount", int'(runCount), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, i, i + 4, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("tmo.nextGo", int'(go), 1);
    checkOutput("tmo.errSticky", int'(timeoutErr), 1);
    drainRuns();

    // Reset on the second FEED beat.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 2 * i + 1, 2 * i + 2, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("midRst.beat2", int'(a), 3);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("midRst.count", int'(fifoCount), 0);
    checkOutput("midRst.feed", int'(feedValid), 0);
    checkOutput("midRst.go", int'(go), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 15 - i, i, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("midRst.nextGo", int'(go), 1);
    drainRuns();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom % 2, $urandom % 16, $urandom % 16,
                    (($urandom % 4) == 0) ? 1 : 0, (($urandom % 200) == 0) ? 1 : 0);
    end
    drainRuns();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mac_operand_feeder.md
# mac_operand_feeder

Upstream stage of the 4-bit MAC core. Buffers host-supplied operand pairs in a small FIFO and, whenever a full run of `TERMS` pairs is available, launches a MAC run by pulsing `go`. It then streams one pair per cycle on `a`/`b` and waits for the core's `done`. A watchdog flags a core that never completes.

## Interface
- `DEPTH`, 16: FIFO depth in operand pairs; power of two, ≥ `TERMS`.
- `TERMS`, 4: pairs per MAC run; 1..`DEPTH`.
- `TIMEOUT`, 64: maximum cycles allowed in `WAIT_DONE` before an error is flagged; ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  host offers a pair.
- `in_a`  in  4  host operand A.
- `in_b`  in  4  host operand B.
- `in_ready`  out  1  FIFO can accept a pair; equals `fifo_count != DEPTH`.
- `go`  out  1  one-cycle run-start pulse to the MAC core.
- `a`  out  4  operand A to the core.
- `b`  out  4  operand B to the core.
- `feed_valid`  out  1  `a`/`b` carry a live pair this cycle.
- `done`  in  1  run-complete from the MAC core.
- `busy`  out  1  high in any state other than `IDLE`.
- `fifo_count`  out  clog2(DEPTH)+1  pairs currently buffered.
- `run_count`  out  8  completed runs; wraps 255→0.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- Push: when `in_valid && in_ready` at an edge, `{in_a,in_b}` is written at the write pointer. Pointers wrap modulo `DEPTH`.
- Pop: occurs in every `FEED` cycle.
- Simultaneous push and pop: `fifo_count` is unchanged and both pointers advance.
- `in_ready` is based on the current count only. When full, a pop in the same cycle does not raise `in_ready`.
- FSM states and transitions:
  - `IDLE`: go to `START` when `fifo_count >= TERMS`.
  - `START`: `go`=1 for exactly this cycle; go to `FEED`.
  - `FEED`: lasts `TERMS` cycles, tracked by an internal beat counter. Each cycle presents the FIFO head on `a`/`b` with `feed_valid`=1 and pops it. After the last beat, go to `WAIT_DONE`.
  - `WAIT_DONE`: a watchdog counter runs.
    - If `done`=1: go to `IDLE` and increment `run_count`.
    - Else, if the watchdog reaches `TIMEOUT`: set `timeout_err`, go to `IDLE`, leave `run_count` unchanged.
- `done` is ignored in every state except `WAIT_DONE`.
- The FIFO can never underflow in `FEED`, because entry into a run requires `TERMS` pairs to be buffered.
- Outside `FEED`, `a`, `b` and `feed_valid` are 0.
- `timeout_err` clears only on `rst`.
- Host pushes are accepted in every state, including during a run.

## Timing
- Reset values: `go`, `a`, `b`, `feed_valid`, `busy`, `fifo_count`, `run_count`, `timeout_err` are all 0; `in_ready` is 1; FIFO is empty; state is `IDLE`.
- All outputs are registered, except `in_ready`, which is decoded from `fifo_count`.
- Run timeline, with edge E being the one at which `fifo_count` first reaches ≥ `TERMS`:
  - `go`=1 during cycle E+1 (`START`).
  - Pairs 0..TERMS−1 appear in cycles E+2 .. E+1+TERMS.
  - `WAIT_DONE` begins at E+2+TERMS.
- `done` sampled high in cycle d: state is `IDLE` and `run_count` is incremented in cycle d+1. The next `go` is no earlier than d+2, so `IDLE` always lasts at least one cycle.
- Watchdog: entering `WAIT_DONE` at cycle w with no `done` sets `timeout_err` and returns to `IDLE` in cycle w+`TIMEOUT`.
- `rst` asserted in any state, including mid-`FEED`: at the next edge all reset values apply, the FIFO is flushed, and the beat and watchdog counters clear.

## Test plan
- Reset: assert `rst` for 2 cycles after random activity → all outputs at their reset values, `in_ready`=1.
- Single run (defaults):
  - Stimulus: push (1,2), (3,4), (5,6), (7,8) back-to-back.
  - Response: `go` pulses one cycle; `a`/`b` = 1/2, 3/4, 5/6, 7/8 on consecutive cycles with `feed_valid`=1; `fifo_count` ends at 0.
  - Then drive `done` for 1 cycle → `run_count`=1, `busy`=0.
- Full FIFO:
  - Hold the core off by not issuing `done` while pushing 20 pairs.
  - Expected: the first 4 pairs feed; `fifo_count` saturates at 16 with `in_ready`=0; extra offers are not accepted; no data is lost on later runs.
- Simultaneous push and pop: keep `in_valid`=1 throughout `FEED` starting from count=5 → count stays 5 during `FEED`, and pair order is preserved.
- Timeout: one run with `done` held 0 → `timeout_err`=1 exactly 64 cycles after `WAIT_DONE` entry; `run_count` unchanged; the next run still launches.
- Reset mid-`FEED`: assert `rst` on the 2nd beat → next cycle `fifo_count`=0, `feed_valid`=0, `go`=0; a subsequent 4-pair push runs normally.
